// File: rtl/crc_frame_pkg.sv
// Shared types and constants for the CRC frame builder: FSM state encoding,
// default bus geometry and the WAIT_CRC timeout length.
package crc_frame_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_DEPTH   = 8;
  localparam int CRC_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WAIT_CRC,
    SEND,
    SEND_CRC
  } state_t;

endpackage

// File: rtl/crc_frame_builder_if.sv
// Word stream with valid/ready handshake and an end-of-frame marker.
// The master drives data/valid/last; the slave returns ready.
interface crc_frame_builder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             last;
  logic             ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/crc_frame_fifo.sv
// Single-frame payload buffer: write, pop and flush take effect on the clock edge.
// Head word is visible combinationally from storage; the caller must not write when full.
module crc_frame_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr;
  logic             do_pop;

  assign do_wr  = wr_en && !full && !flush;
  assign do_pop = pop && !empty && !flush;

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_wr, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_q];
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/crc_frame_builder.sv
// Buffers one payload frame, then emits payload + CRC word; m_valid one cycle after last word/CRC.
// Payload stalls (s_ready=0) until the frame is sent; output held stable under m_ready=0. Option: CRC_FRAME_TIMEOUT_EN.
module crc_frame_builder
  import crc_frame_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  crc_frame_builder_if.slave  s_if,
  input  logic [WIDTH-1:0]    crc_i,
  input  logic                crc_valid_i,
  crc_frame_builder_if.master m_if,
  output logic                frame_err
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] crc_q;
  logic             crc_seen_q;
  logic             frame_err_q;
  logic             rdy_en_q;

  logic             wr_en, pop, flush;
  logic             ovf, tmo_hit, crc_cap, s_acc, last_word, frame_done;
  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;

  crc_frame_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (s_if.data),
    .pop     (pop),
    .flush   (flush),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef CRC_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(CRC_TIMEOUT);
  logic [TW-1:0] tmo_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == WAIT_CRC) begin
      tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign tmo_hit = (state_q == WAIT_CRC) && !crc_seen_q && !crc_valid_i &&
                   (tmo_cnt_q == TW'(CRC_TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // rdy_en_q keeps s_ready low through reset and for the first edge after it.
  assign s_if.ready = rdy_en_q && !fifo_full && ((state_q == IDLE) || (state_q == FILL));
  assign m_if.valid = ((state_q == SEND) && !fifo_empty) || (state_q == SEND_CRC);
  assign m_if.last  = (state_q == SEND_CRC);
  assign m_if.data  = (state_q == SEND)     ? fifo_head :
                      (state_q == SEND_CRC) ? crc_q     : '0;
  assign frame_err  = frame_err_q;

  assign s_acc      = s_if.valid && s_if.ready;
  assign last_word  = s_if.last || (fifo_count == CW'(DEPTH - 1));
  assign crc_cap    = crc_valid_i && ((state_q == FILL) || (state_q == WAIT_CRC));
  assign frame_done = (state_q == SEND_CRC) && m_if.ready;

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    ovf     = 1'b0;
    case (state_q)
      IDLE, FILL: begin
        if (s_acc) begin
          wr_en   = 1'b1;
          state_d = FILL;
          if (last_word) begin
            ovf = !s_if.last;
            // A CRC already latched (or arriving now) skips WAIT_CRC entirely.
            if ((state_q == FILL) && (crc_seen_q || crc_valid_i)) begin
              state_d = SEND;
            end else begin
              state_d = WAIT_CRC;
            end
          end
        end
      end
      WAIT_CRC: begin
        if (crc_seen_q || crc_valid_i) begin
          state_d = SEND;
        end else if (tmo_hit) begin
          flush   = 1'b1;
          state_d = IDLE;
        end
      end
      SEND: begin
        if (m_if.ready && !fifo_empty) begin
          pop = 1'b1;
          if (fifo_count == CW'(1)) begin
            state_d = SEND_CRC;
          end
        end
      end
      SEND_CRC: begin
        if (m_if.ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      crc_q       <= '0;
      crc_seen_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_err_q <= ovf || tmo_hit;
      rdy_en_q    <= 1'b1;
      if (crc_cap) begin
        crc_q      <= crc_i;
        crc_seen_q <= 1'b1;
      end else if (frame_done || tmo_hit) begin
        crc_seen_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crc_frame_builder.sv
// Directed bench for crc_frame_builder: per-cycle vector table plus
// hand-written stall, reset and (optionally) timeout sequences.
module tb_crc_frame_builder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] crc_i = '0;
  logic        crc_valid_i = 1'b0;
  logic        frame_err;

  crc_frame_builder_if #(.WIDTH(16)) s_if ();
  crc_frame_builder_if #(.WIDTH(16)) m_if ();

  crc_frame_builder #(.WIDTH(16), .DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_if        (s_if),
    .crc_i       (crc_i),
    .crc_valid_i (crc_valid_i),
    .m_if        (m_if),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [15:0] sd;
    logic        sl;
    logic        cv;
    logic [15:0] cd;
    logic        mr;
    logic        e_sr;
    logic        e_mv;
    logic [15:0] e_md;
    logic        e_ml;
    logic        e_fe;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input logic sv, input logic [15:0] sd, input logic sl,
                     input logic cv, input logic [15:0] cd, input logic mr,
                     input logic e_sr, input logic e_mv, input logic [15:0] e_md,
                     input logic e_ml, input logic e_fe);
    vec_t v;
    v.sv = sv; v.sd = sd; v.sl = sl; v.cv = cv; v.cd = cd; v.mr = mr;
    v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md; v.e_ml = e_ml; v.e_fe = e_fe;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic put(input logic sv, input logic [15:0] sd, input logic sl,
                     input logic cv, input logic [15:0] cd);
    s_if.valid  = sv;
    s_if.data   = sd;
    s_if.last   = sl;
    crc_valid_i = cv;
    crc_i       = cd;
  endtask

  task automatic chk_out(input string tag, input int idx, input logic e_sr,
                         input logic e_mv, input logic [15:0] e_md,
                         input logic e_ml, input logic e_fe);
    chk({tag, ".s_ready"},   idx, 32'(s_if.ready), 32'(e_sr));
    chk({tag, ".m_valid"},   idx, 32'(m_if.valid), 32'(e_mv));
    chk({tag, ".m_data"},    idx, 32'(m_if.data),  32'(e_md));
    chk({tag, ".m_last"},    idx, 32'(m_if.last),  32'(e_ml));
    chk({tag, ".frame_err"}, idx, 32'(frame_err),  32'(e_fe));
  endtask

  initial begin
    logic [15:0] exp_words [4];
    logic [3:0]  rdy_pat;
    int          idx;
    int          waited;

    put(0, 16'h0, 0, 0, 16'h0);
    m_if.ready = 1'b1;

    // Frame 1: 3 words, CRC two cycles after the last word.
    add(1,16'hAAFF,0, 0,16'h0000, 1,  1,0,16'h0000,0,0);
    add(1,16'h1234,0, 0,16'h0000, 1,  1,0,16'h0000,0,0);
    add(1,16'h00FF,1, 0,16'h0000, 1,  1,0,16'h0000,0,0);
    add(0,16'h0000,0, 0,16'h0000, 1,  0,0,16'h0000,0,0);
    add(0,16'h0000,0, 1,16'hBEEF, 1,  0,0,16'h0000,0,0);
    add(0,16'h0000,0, 0,16'h0000, 1,  0,1,16'hAAFF,0,0);
    add(0,16'h0000,0, 0,16'h0000, 1,  0,1,16'h1234,0,0);
    add(0,16'h0000,0, 0,16'h0000, 1,  0,1,16'h00FF,0,0);
    add(0,16'h0000,0, 0,16'h0000, 1,  0,1,16'hBEEF,1,0);
    add(0,16'h0000,0, 0,16'h0000, 1,  1,0,16'h0000,0,0);
    // Frame 2: CRC strobed during FILL; strobe during SEND must be ignored.
    add(1,16'h0001,0, 0,16'h0000, 1,  1,0,16'h0000,0,0);
    add(1,16'h0002,0, 1,16'h5A5A, 1,  1,0,16'h0000,0,0);
    add(1,16'h0003,1, 0,16'h0000, 1,  1,0,16'h0000,0,0);
    add(0,16'h0000,0, 0,16'h0000, 1,  0,1,16'h0001,0,0);
    add(0,16'h0000,0, 1,16'hDEAD, 1,  0,1,16'h0002,0,0);
    add(0,16'h0000,0, 0,16'h0000, 1,  0,1,16'h0003,0,0);
    add(0,16'h0000,0, 0,16'h0000, 1,  0,1,16'h5A5A,1,0);
    add(0,16'h0000,0, 0,16'h0000, 1,  1,0,16'h0000,0,0);
    // Frame 3: 8 words without s_last -> overflow, frame_err pulse.
    for (int i = 0; i < 8; i++)
      add(1,16'h0100 + 16'(i),0, 0,16'h0000, 1,  1,0,16'h0000,0,0);
    add(1,16'hFFFF,1, 0,16'h0000, 1,  0,0,16'h0000,0,1);
    add(0,16'h0000,0, 1,16'hC0DE, 1,  0,0,16'h0000,0,0);
    for (int i = 0; i < 8; i++)
      add(0,16'h0000,0, 0,16'h0000, 1,  0,1,16'h0100 + 16'(i),0,0);
    add(0,16'h0000,0, 0,16'h0000, 1,  0,1,16'hC0DE,1,0);
    add(0,16'h0000,0, 0,16'h0000, 1,  1,0,16'h0000,0,0);

    // Reset state.
    @(negedge clk);
    #1 chk_out("reset", 0, 0, 0, 16'h0000, 0, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      put(vecs[i].sv, vecs[i].sd, vecs[i].sl, vecs[i].cv, vecs[i].cd);
      m_if.ready = vecs[i].mr;
      #1 chk_out("vec", i, vecs[i].e_sr, vecs[i].e_mv, vecs[i].e_md,
                 vecs[i].e_ml, vecs[i].e_fe);
      @(negedge clk);
    end

    // Stalled output: ready pattern 1,0,0,1 repeating.
    put(1, 16'h1111, 0, 0, 16'h0); @(negedge clk);
    put(1, 16'h2222, 0, 0, 16'h0); @(negedge clk);
    put(1, 16'h3333, 1, 0, 16'h0); @(negedge clk);
    put(0, 16'h0000, 0, 1, 16'h4444); @(negedge clk);
    put(0, 16'h0000, 0, 0, 16'h0);
    exp_words[0] = 16'h1111; exp_words[1] = 16'h2222;
    exp_words[2] = 16'h3333; exp_words[3] = 16'h4444;
    rdy_pat = 4'b1001;
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
      m_if.ready = rdy_pat[3 - (cyc % 4)];
      #1;
      chk("stall.m_valid", cyc, 32'(m_if.valid), 32'd1);
      chk("stall.m_data",  cyc, 32'(m_if.data),  32'(exp_words[idx]));
      chk("stall.m_last",  cyc, 32'(m_if.last),  32'(idx == 3));
      if (m_if.ready) idx++;
      @(negedge clk);
    end
    m_if.ready = 1'b1;
    chk("stall.words_sent", 0, 32'(idx), 32'd4);
    #1 chk_out("stall.after", 0, 1, 0, 16'h0000, 0, 0);
    @(negedge clk);

    // Reset while waiting for the CRC; partial frame must vanish.
    put(1, 16'h5555, 0, 0, 16'h0); @(negedge clk);
    put(1, 16'h6666, 1, 0, 16'h0); @(negedge clk);
    put(0, 16'h0000, 0, 0, 16'h0);
    rst = 1'b0;
    #1 chk_out("rst_mid", 0, 0, 0, 16'h0000, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1 chk_out("rst_mid", 1, 1, 0, 16'h0000, 0, 0);
    // Fresh frame with CRC strobed in the same cycle as the last word.
    put(1, 16'h7777, 0, 0, 16'h0); @(negedge clk);
    put(1, 16'h7778, 1, 1, 16'h8888); @(negedge clk);
    put(0, 16'h0000, 0, 0, 16'h0);
    #1 chk_out("post_rst", 0, 0, 1, 16'h7777, 0, 0);
    @(negedge clk);
    #1 chk_out("post_rst", 1, 0, 1, 16'h7778, 0, 0);
    @(negedge clk);
    #1 chk_out("post_rst", 2, 0, 1, 16'h8888, 1, 0);
    @(negedge clk);
    #1 chk_out("post_rst", 3, 1, 0, 16'h0000, 0, 0);
    @(negedge clk);

`ifdef CRC_FRAME_TIMEOUT_EN
    put(1, 16'h9999, 1, 0, 16'h0); @(negedge clk);
    put(0, 16'h0000, 0, 0, 16'h0);
    waited = 0;
    while (!frame_err && waited < 200) begin
      #1 chk("tmo.m_valid", waited, 32'(m_if.valid), 32'd0);
      @(negedge clk);
      waited++;
    end
    chk("tmo.cycles", 0, 32'(waited), 32'd64);
    #1 chk_out("tmo.pulse", 0, 1, 0, 16'h0000, 0, 1);
    @(negedge clk);
    #1 chk_out("tmo.after", 0, 1, 0, 16'h0000, 0, 0);
`else
    waited = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
